// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Used by muldiv_ctrl and muldiv_watchdog.
package muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_EXC   = 3'd5,
    ST_ABORT = 3'd6
  } state_t;

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog: clearable counter that flags expiry
// once it reaches TIMEOUT_CYCLES-1 and then holds there.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = muldiv_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

  // count stalled WAIT cycles, restarting on each new operation
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiplier/divider and HI/LO writeback.
// Define MULDIV_TIMEOUT_EN to add the WAIT watchdog and ABORT.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic op,
  input  logic mult_fim,
  input  logic div_fim,
  input  logic div_zero,
  output logic busy,
  output logic done,
  output logic mult_start,
  output logic div_start,
  output logic hi_write,
  output logic lo_write,
  output logic hi_sel,
  output logic lo_sel,
  output logic exc_div0,
  output logic exc_timeout
);

  state_t state;
  logic   op_r;
  logic   fim_sel;

  assign fim_sel = (op_r == OP_DIV) ? div_fim : mult_fim;
  assign hi_sel  = op_r;
  assign lo_sel  = op_r;

`ifdef MULDIV_TIMEOUT_EN
  logic wd_expired;

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_START),
    .enable ((state == ST_WAIT) && !fim_sel),
    .expired(wd_expired)
  );
`else
  assign exc_timeout = 1'b0;
`endif

  // FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_r       <= OP_MULT;
      busy       <= 1'b0;
      done       <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_write   <= 1'b0;
      lo_write   <= 1'b0;
      exc_div0   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      exc_timeout <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_write   <= 1'b0;
      lo_write   <= 1'b0;
      exc_div0   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      exc_timeout <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            op_r       <= op;
            state      <= ST_START;
            busy       <= 1'b1;
            mult_start <= (op == OP_MULT);
            div_start  <= (op == OP_DIV);
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fim_sel) begin
            if ((op_r == OP_DIV) && div_zero) begin
              state    <= ST_EXC;
              exc_div0 <= 1'b1;
              done     <= 1'b1;
            end else begin
              state    <= ST_WRITE;
              hi_write <= 1'b1;
              lo_write <= 1'b1;
            end
          end
`ifdef MULDIV_TIMEOUT_EN
          else if (wd_expired) begin
            state       <= ST_ABORT;
            exc_timeout <= 1'b1;
            done        <= 1'b1;
          end
`endif
        end
        ST_WRITE: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE, ST_EXC, ST_ABORT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
